tram_ctrl: RTL and testbench

Textmode RAM controller sitting between the CPU bus and the system port of the text RAM. It shares that single read-write port between CPU accesses and a built-in block engine that performs FILL (clear screen, set attributes) and COPY (scroll) operations. The CPU always has priority, and the engine runs in the cycles the CPU leaves free.

---
 rtl/tram_ctrl_if.sv | 52 +++++
 rtl/tram_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_tram_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tram_ctrl_if.sv
// tram_ctrl_if: CPU, block-command and TRAM system-port signals of tram_ctrl.
// The slave modport is the controller's view; master is the surrounding system.
interface tram_ctrl_if #(
  parameter int unsigned WORD     = 32,
  parameter int unsigned BYTE_CNT = 4,
  parameter int unsigned ADDRW    = 14
);

  // CPU bus
  logic                cpu_req;
  logic [BYTE_CNT-1:0] cpu_we;
  logic [ADDRW-1:0]    cpu_addr;
  logic [WORD-1:0]     cpu_din;
  logic [WORD-1:0]     cpu_dout;
  logic                cpu_ack;

  // Block engine command channel
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_op;
  logic [ADDRW-1:0]    cmd_src;
  logic [ADDRW-1:0]    cmd_dst;
  logic [ADDRW:0]      cmd_len;
  logic [WORD-1:0]     cmd_data;
  logic                busy;
  logic                done;

  // TRAM system port
  logic [BYTE_CNT-1:0] tram_we;
  logic [ADDRW-1:0]    tram_addr;
  logic [WORD-1:0]     tram_din;
  logic [WORD-1:0]     tram_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din,
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data,
    input  tram_dout,
    output cpu_dout, cpu_ack,
    output cmd_ready, busy, done,
    output tram_we, tram_addr, tram_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din,
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_len, cmd_data,
    output tram_dout,
    input  cpu_dout, cpu_ack,
    input  cmd_ready, busy, done,
    input  tram_we, tram_addr, tram_din
  );

endinterface

// File: rtl/tram_ctrl.sv
// tram_ctrl: shares the TRAM system port between CPU accesses (always first)
// and a FILL/COPY block engine that uses the cycles the CPU leaves free.
// Build option: define TRAM_CTRL_COPY_EN to include the COPY datapath
// (CP_RD/CP_WR states and the read hold register). Without it a COPY
// command is accepted and completes on the next cycle with no TRAM access.
module tram_ctrl #(
  parameter int unsigned WORD     = 32,
  parameter int unsigned BYTE_CNT = 4,
  parameter int unsigned ADDRW    = 14
) (
  input  logic       clk_sys,
  input  logic       rst_sys_n,
  tram_ctrl_if.slave bus
);

  localparam int unsigned LENW = ADDRW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
`ifdef TRAM_CTRL_COPY_EN
    S_CP_RD = 3'd2,
    S_CP_WR = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDRW-1:0]    dst_q, dst_d;
  logic [LENW-1:0]     cnt_q, cnt_d;
  logic [WORD-1:0]     fill_q, fill_d;

  logic [BYTE_CNT-1:0] eng_we;
  logic [ADDRW-1:0]    eng_addr;
  logic [WORD-1:0]     eng_din;
  logic                stall;

  logic                ack_q;
  logic                ack_rd_q;
  logic [WORD-1:0]     dout_q;

`ifdef TRAM_CTRL_COPY_EN
  logic [ADDRW-1:0]    src_q, src_d;
  logic                down_q, down_d;
  logic                rd_pend_q;
  logic [WORD-1:0]     hold_q;
  logic [WORD-1:0]     cp_word;
`else
  logic                unused_c;
  assign unused_c = ^bus.cmd_src;
`endif

  // A CPU request owns the port this cycle; any engine state holds.
  assign stall = bus.cpu_req;

`ifdef TRAM_CTRL_COPY_EN
  // Right after the engine read, the word is still on tram_dout; later it
  // comes from the hold register because CPU traffic may overwrite tram_dout.
  assign cp_word = rd_pend_q ? bus.tram_dout : hold_q;
`endif

  // Engine next-state, address/count update and engine port request
  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    fill_d   = fill_q;
    eng_we   = '0;
    eng_addr = '0;
    eng_din  = '0;
`ifdef TRAM_CTRL_COPY_EN
    src_d    = src_q;
    down_d   = down_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          dst_d  = bus.cmd_dst;
          cnt_d  = bus.cmd_len;
          fill_d = bus.cmd_data;
`ifdef TRAM_CTRL_COPY_EN
          src_d  = bus.cmd_src;
          down_d = 1'b0;
          // Overlapping scroll-down must copy from the top end downwards.
          if (bus.cmd_op && (bus.cmd_dst > bus.cmd_src)) begin
            down_d = 1'b1;
            src_d  = bus.cmd_src + ADDRW'(bus.cmd_len - LENW'(1));
            dst_d  = bus.cmd_dst + ADDRW'(bus.cmd_len - LENW'(1));
          end
          if (bus.cmd_len == '0) begin
            state_d = S_DONE;
          end else if (bus.cmd_op) begin
            state_d = S_CP_RD;
          end else begin
            state_d = S_FILL;
          end
`else
          if ((bus.cmd_len == '0) || bus.cmd_op) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FILL;
          end
`endif
        end
      end
      S_FILL: begin
        eng_we   = '1;
        eng_addr = dst_q;
        eng_din  = fill_q;
        if (!stall) begin
          dst_d = dst_q + ADDRW'(1);
          cnt_d = cnt_q - LENW'(1);
          if (cnt_q == LENW'(1)) begin
            state_d = S_DONE;
          end
        end
      end
`ifdef TRAM_CTRL_COPY_EN
      S_CP_RD: begin
        eng_addr = src_q;
        if (!stall) begin
          state_d = S_CP_WR;
        end
      end
      S_CP_WR: begin
        eng_we   = '1;
        eng_addr = dst_q;
        eng_din  = cp_word;
        if (!stall) begin
          if (down_q) begin
            src_d = src_q - ADDRW'(1);
            dst_d = dst_q - ADDRW'(1);
          end else begin
            src_d = src_q + ADDRW'(1);
            dst_d = dst_q + ADDRW'(1);
          end
          cnt_d   = cnt_q - LENW'(1);
          state_d = (cnt_q == LENW'(1)) ? S_DONE : S_CP_RD;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Engine state and command registers
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= S_IDLE;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

`ifdef TRAM_CTRL_COPY_EN
  // COPY source/direction and capture of the word read by CP_RD
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      src_q     <= '0;
      down_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      src_q     <= src_d;
      down_q    <= down_d;
      rd_pend_q <= (state_q == S_CP_RD) && !stall;
      if (rd_pend_q) begin
        hold_q <= bus.tram_dout;
      end
    end
  end
`endif

  // CPU acknowledge and read-data hold
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      ack_q    <= 1'b0;
      ack_rd_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      ack_q    <= bus.cpu_req;
      ack_rd_q <= bus.cpu_req && (bus.cpu_we == '0);
      if (ack_rd_q) begin
        dout_q <= bus.tram_dout;
      end
    end
  end

  // CPU response: read data straight from the TRAM in the ack cycle, held after
  assign bus.cpu_ack  = ack_q;
  assign bus.cpu_dout = ack_rd_q ? bus.tram_dout : dout_q;

  // Command channel status decoded from the state register
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

  // TRAM port mux: CPU first, engine otherwise
  assign bus.tram_we   = stall ? bus.cpu_we   : eng_we;
  assign bus.tram_addr = stall ? bus.cpu_addr : eng_addr;
  assign bus.tram_din  = stall ? bus.cpu_din  : eng_din;

endmodule

// File: tb/tb_tram_ctrl.sv
// tb_tram_ctrl: randomized bench for tram_ctrl with a TRAM model and a
// word-array reference of the expected RAM contents and response timing.
// Honours TRAM_CTRL_COPY_EN the same way as the design.
module tb_tram_ctrl;

  localparam int unsigned WORD     = 32;
  localparam int unsigned BYTE_CNT = 4;
  localparam int unsigned ADDRW    = 14;
  localparam int unsigned DEPTH    = 1 << ADDRW;

  logic clk_sys = 1'b0;
  logic rst_sys_n;

  always #5 clk_sys = ~clk_sys;

  tram_ctrl_if #(.WORD(WORD), .BYTE_CNT(BYTE_CNT), .ADDRW(ADDRW)) bus ();

  tram_ctrl #(.WORD(WORD), .BYTE_CNT(BYTE_CNT), .ADDRW(ADDRW)) dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [WORD-1:0] pattern(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hC3C3_0000;
  endfunction

  // TRAM model: synchronous RAM, output register not updated on writes
  logic [WORD-1:0]  mem [DEPTH];
  bit               mem_init = 1'b0;
  int               wr_cnt = 0;
  logic [ADDRW-1:0] wr_addr [64];

  always @(posedge clk_sys) begin
    if (!mem_init) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= pattern(i);
      mem_init <= 1'b1;
    end else if (bus.tram_we != '0) begin
      for (int b = 0; b < int'(BYTE_CNT); b++)
        if (bus.tram_we[b]) mem[bus.tram_addr][8*b +: 8] <= bus.tram_din[8*b +: 8];
      if (!bus.cpu_req) begin
        wr_addr[wr_cnt % 64] <= bus.tram_addr;
        wr_cnt <= wr_cnt + 1;
      end
    end else begin
      bus.tram_dout <= mem[bus.tram_addr];
    end
  end

  // Reference contents and CPU response expectations
  logic [WORD-1:0] ref_mem [DEPTH];
  bit              pend_req = 1'b0;
  bit              pend_rd = 1'b0;
  logic [WORD-1:0] pend_data = '0;
  logic [WORD-1:0] last_rd = '0;
  int              acc_cyc = -1;
  int              done_cyc = -1;
  bit              done_seen = 1'b0;

  function automatic bit mbit(input logic [63:0] m, input int j);
    return (j < 64) ? m[j] : 1'b0;
  endfunction

  // Engine cycles a command needs when nothing stalls it
  function automatic int exp_work(input bit op, input int len);
    if (!op) return len;
`ifdef TRAM_CTRL_COPY_EN
    return 2 * len;
`else
    return 0;
`endif
  endfunction

  function automatic void ref_fill(input logic [ADDRW-1:0] dst, input int len,
                                   input logic [WORD-1:0] data);
    for (int i = 0; i < len; i++) ref_mem[ADDRW'(int'(dst) + i)] = data;
  endfunction

  function automatic void ref_copy(input logic [ADDRW-1:0] src, input logic [ADDRW-1:0] dst,
                                   input int len);
`ifdef TRAM_CTRL_COPY_EN
    if (dst > src) begin
      for (int i = len - 1; i >= 0; i--)
        ref_mem[ADDRW'(int'(dst) + i)] = ref_mem[ADDRW'(int'(src) + i)];
    end else begin
      for (int i = 0; i < len; i++)
        ref_mem[ADDRW'(int'(dst) + i)] = ref_mem[ADDRW'(int'(src) + i)];
    end
`endif
  endfunction

  // One clock cycle: drive CPU inputs, check last cycle's ack, note done/accept
  task automatic tick(input bit req, input logic [BYTE_CNT-1:0] we,
                      input logic [ADDRW-1:0] a, input logic [WORD-1:0] d);
    logic [WORD-1:0] exp_dout;
    bus.cpu_req  = req;
    bus.cpu_we   = we;
    bus.cpu_addr = a;
    bus.cpu_din  = d;
    @(negedge clk_sys);
    n_checks++;
    if (bus.cpu_ack !== pend_req) begin
      n_errors++;
      $display("FAIL cpu_ack cyc=%0d got=%b exp=%b", cyc, bus.cpu_ack, pend_req);
    end
    if (pend_req) begin
      exp_dout = pend_rd ? pend_data : last_rd;
      n_checks++;
      if (bus.cpu_dout !== exp_dout) begin
        n_errors++;
        $display("FAIL cpu_dout cyc=%0d got=%h exp=%h", cyc, bus.cpu_dout, exp_dout);
      end
      if (pend_rd) last_rd = pend_data;
    end
    if (req) begin
      n_checks++;
      if (bus.tram_addr !== a || bus.tram_we !== we || (we != '0 && bus.tram_din !== d)) begin
        n_errors++;
        $display("FAIL cpu_port_mux cyc=%0d got addr=%h we=%b exp addr=%h we=%b",
                 cyc, bus.tram_addr, bus.tram_we, a, we);
      end
    end
    if (bus.done === 1'b1) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      n_checks++;
      if (bus.cmd_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL ready_in_done cyc=%0d got=%b exp=0", cyc, bus.cmd_ready);
      end
    end
    if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) acc_cyc = cyc;
    pend_req = req;
    pend_rd  = req && (we == '0);
    if (req) begin
      if (pend_rd) pend_data = ref_mem[a];
      else
        for (int b = 0; b < int'(BYTE_CNT); b++)
          if (we[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, '0, '0, '0);
  endtask

  task automatic issue(input bit op, input logic [ADDRW-1:0] src, input logic [ADDRW-1:0] dst,
                       input int len, input logic [WORD-1:0] data, output int wr0);
    bus.cmd_op    = op;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_len   = (ADDRW + 1)'(len);
    bus.cmd_data  = data;
    bus.cmd_valid = 1'b1;
    acc_cyc   = -1;
    done_seen = 1'b0;
    wr0 = wr_cnt;
    idle();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (acc_cyc != cyc - 1) begin
      n_errors++;
      $display("FAIL cmd_accept cyc=%0d got_acc=%0d exp_acc=%0d", cyc, acc_cyc, cyc - 1);
    end
  endtask

  // Run until done, injecting CPU accesses where mask bits are set
  task automatic engine_run(input int work, input logic [63:0] mask, input bit cpu_wr,
                            input string name);
    int j = 0, w = 0, k = 0, exp_lat;
    logic [ADDRW-1:0] a;
    while (w < work && j < 200) begin
      if (!mbit(mask, j)) w++;
      j++;
    end
    exp_lat = j + 1;
    while (!done_seen && k < 400) begin
      if (mbit(mask, k)) begin
        a = 14'h2000 | ADDRW'($urandom_range(0, 255));
        if (cpu_wr) tick(1'b1, BYTE_CNT'($urandom_range(1, 15)), a, $urandom);
        else        tick(1'b1, '0, a, '0);
      end else begin
        idle();
      end
      k++;
    end
    n_checks++;
    if (!done_seen || (done_cyc - acc_cyc) != exp_lat) begin
      n_errors++;
      $display("FAIL %s done_latency got=%0d exp=%0d (seen=%b)", name,
               done_seen ? done_cyc - acc_cyc : -1, exp_lat, done_seen);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL %s after_done got busy=%b ready=%b done=%b exp 0/1/0", name,
               bus.busy, bus.cmd_ready, bus.done);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0, first = -1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem[i] !== ref_mem[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL %s mem bad_words=%0d first_addr=%h got=%h exp=%h", name, bad, first,
               mem[first], ref_mem[first]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if (bus.cpu_ack !== 1'b0 || bus.cpu_dout !== '0 || bus.cmd_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tram_we !== '0 ||
        bus.tram_addr !== '0 || bus.tram_din !== '0) begin
      n_errors++;
      $display("FAIL %s got ack=%b dout=%h ready=%b busy=%b done=%b we=%b addr=%h din=%h exp 0/0/1/0/0/0/0/0",
               name, bus.cpu_ack, bus.cpu_dout, bus.cmd_ready, bus.busy, bus.done,
               bus.tram_we, bus.tram_addr, bus.tram_din);
    end
  endtask

  task automatic test_reset();
    rst_sys_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset_outputs("reset_state");
    rst_sys_n = 1'b1;
    idle();
    check_reset_outputs("after_release");
  endtask

  task automatic test_cpu_basic();
    tick(1'b1, 4'b1111, 14'h0010, 32'hAABB_CCDD);
    tick(1'b1, 4'b0011, 14'h0010, 32'h1122_3344);
    tick(1'b1, 4'b0000, 14'h0010, '0);
    idle();
    n_checks++;
    if (bus.cpu_dout !== 32'hAABB_3344) begin
      n_errors++;
      $display("FAIL cpu_merge_read got=%h exp=aabb3344", bus.cpu_dout);
    end
  endtask

  task automatic test_cpu_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0)
        tick(1'b1, ($urandom_range(0, 1) == 0) ? '0 : BYTE_CNT'($urandom_range(1, 15)),
             14'h2000 | ADDRW'($urandom_range(0, 15)), $urandom);
      else
        idle();
    end
    idle();
    check_mem("cpu_random");
  endtask

  task automatic test_fill_wrap();
    int wr0;
    logic [ADDRW-1:0] exp_a [4];
    exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
    issue(1'b0, '0, 14'h3FFE, 4, 32'h0000_0020, wr0);
    engine_run(4, '0, 1'b0, "fill_wrap");
    n_checks++;
    if (wr_cnt - wr0 != 4) begin
      n_errors++;
      $display("FAIL fill_wrap write_count got=%0d exp=4", wr_cnt - wr0);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_addr[(wr0 + i) % 64] !== exp_a[i]) begin
        n_errors++;
        $display("FAIL fill_wrap write_addr[%0d] got=%h exp=%h", i, wr_addr[(wr0 + i) % 64], exp_a[i]);
      end
    end
    ref_fill(14'h3FFE, 4, 32'h0000_0020);
    check_mem("fill_wrap");
  endtask

  task automatic test_fill_stall();
    int wr0;
    logic [WORD-1:0] d = $urandom;
    issue(1'b0, '0, 14'h0100, 8, d, wr0);
    engine_run(8, 64'h4A, 1'b0, "fill_stall");
    ref_fill(14'h0100, 8, d);
    check_mem("fill_stall");
  endtask

  task automatic test_copy();
    int wr0;
    logic [WORD-1:0] w [4];
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      tick(1'b1, 4'b1111, ADDRW'(i), w[i]);
    end
    idle();
    issue(1'b1, 14'h0000, 14'h0002, 4, '0, wr0);
    engine_run(exp_work(1'b1, 4), '0, 1'b0, "copy_down");
`ifdef TRAM_CTRL_COPY_EN
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wr_addr[(wr0 + i) % 64] !== ADDRW'(5 - i)) begin
        n_errors++;
        $display("FAIL copy_down order[%0d] got=%h exp=%h", i, wr_addr[(wr0 + i) % 64], ADDRW'(5 - i));
      end
    end
`else
    n_checks++;
    if (wr_cnt != wr0) begin
      n_errors++;
      $display("FAIL copy_disabled writes got=%0d exp=0", wr_cnt - wr0);
    end
`endif
    ref_copy(14'h0000, 14'h0002, 4);
    check_mem("copy_down");
  endtask

  task automatic test_copy_stall();
    int wr0;
    issue(1'b1, 14'h0300, 14'h0280, 6, '0, wr0);
    engine_run(exp_work(1'b1, 6), 64'h3E, 1'b1, "copy_stall");
    ref_copy(14'h0300, 14'h0280, 6);
    check_mem("copy_stall");
  endtask

  task automatic test_back_to_back();
    int k = 0, acc1, done1;
    bus.cmd_op = 1'b0; bus.cmd_src = '0; bus.cmd_dst = 14'h0800;
    bus.cmd_len = 15'd2; bus.cmd_data = 32'hCAFE_0001;
    bus.cmd_valid = 1'b1;
    acc_cyc = -1; done_seen = 1'b0;
    idle();
    acc1 = acc_cyc;
    while (!done_seen && k < 20) begin idle(); k++; end
    done1 = done_cyc;
    n_checks++;
    if (!done_seen || done1 - acc1 != 3) begin
      n_errors++;
      $display("FAIL b2b_first latency got=%0d exp=3", done1 - acc1);
    end
    bus.cmd_dst = 14'h0810; bus.cmd_len = 15'd3; bus.cmd_data = 32'hCAFE_0002;
    done_seen = 1'b0;
    idle();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (acc_cyc != done1 + 1) begin
      n_errors++;
      $display("FAIL b2b_accept_cycle got=%0d exp=%0d", acc_cyc, done1 + 1);
    end
    engine_run(3, '0, 1'b0, "b2b_second");
    ref_fill(14'h0800, 2, 32'hCAFE_0001);
    ref_fill(14'h0810, 3, 32'hCAFE_0002);
    check_mem("back_to_back");
  endtask

  task automatic test_random_cmds();
    int wr0, len;
    bit op, cpu_wr;
    logic [ADDRW-1:0] src, dst;
    logic [WORD-1:0] d;
    logic [63:0] mask;
    for (int n = 0; n < 12; n++) begin
      op  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 12);
      src = ADDRW'($urandom_range(16, 4000));
      dst = ADDRW'(int'(src) + $urandom_range(0, 16) - 8);
      d   = $urandom;
      cpu_wr = 1'($urandom_range(0, 1));
      for (int b = 0; b < 64; b++) mask[b] = ($urandom_range(0, 3) == 0);
      issue(op, src, dst, len, d, wr0);
      engine_run(exp_work(op, len), mask, cpu_wr, "random_cmd");
      if (op) ref_copy(src, dst, len);
      else    ref_fill(dst, len, d);
      check_mem("random_cmd");
    end
  endtask

  task automatic test_reset_mid_fill();
    int wr0;
    logic [WORD-1:0] d = $urandom;
    tick(1'b1, '0, 14'h2000, '0);
    idle();
    issue(1'b0, '0, 14'h0400, 20, d, wr0);
    repeat (5) idle();
    rst_sys_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_fill");
    repeat (2) @(posedge clk_sys);
    #1;
    rst_sys_n = 1'b1;
    pend_req = 1'b0; pend_rd = 1'b0; last_rd = '0; done_seen = 1'b0;
    repeat (30) idle();
    n_checks++;
    if (done_seen || bus.cmd_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_abort got done_seen=%b ready=%b exp 0/1", done_seen, bus.cmd_ready);
    end
    n_checks++;
    if (wr_cnt - wr0 != 5) begin
      n_errors++;
      $display("FAIL reset_abort write_count got=%0d exp=5", wr_cnt - wr0);
    end
    ref_fill(14'h0400, 5, d);
    check_mem("reset_mid_fill");
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = pattern(i);
    rst_sys_n     = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = '0;
    bus.cpu_addr  = '0;
    bus.cpu_din   = '0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    test_reset();
    test_cpu_basic();
    test_cpu_random();
    test_fill_wrap();
    test_fill_stall();
    test_copy();
    test_copy_stall();
    test_back_to_back();
    test_random_cmds();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
